// File: rtl/adder_pkg.sv
// Shared definitions for the registered 4-bit dataflow adder.
// Holds the operand width and the operand word type used by the adder
// top level, its carry-lookahead core and the testbench.
package adder_pkg;

   // Operand width of the adder datapath.
   localparam int ADDER_WIDTH = 4;

   // One operand or sum word.
   typedef logic [ADDER_WIDTH-1:0] adder_word_t;

endpackage : adder_pkg

// File: rtl/cla_4bit_df.sv
// Purely combinational carry-lookahead adder core in dataflow style.
// Each bit position forms a generate term (a & b) and a propagate term
// (a ^ b). The carry into bit i+1 is generated locally or propagated
// from bit i, starting from the carry-in. Each sum bit is the propagate
// term XOR the carry into that bit.
// Besides the sum and carry-out, the core exposes the carry into the top
// bit. The top level uses it for signed overflow detection.
module cla_4bit_df
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH
)(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             cmsb
);

   // Per-bit generate and propagate terms, and the carry into each bit.
   // c[WIDTH] is the carry out of the whole word.
   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;
   logic [WIDTH:0]   c;

   assign g    = a & b;
   assign p    = a ^ b;
   assign c[0] = cin;

   // Lookahead recurrence: a bit carries out when it generates a carry,
   // or when it propagates the carry arriving from the bit below.
   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : gen_carry
         assign c[i+1] = g[i] | (p[i] & c[i]);
      end
   endgenerate

   assign sum  = p ^ c[WIDTH-1:0];
   assign cout = c[WIDTH];
   assign cmsb = c[WIDTH-1];

endmodule : cla_4bit_df

// File: rtl/adder_4bit_df.sv
// Registered 4-bit binary adder: {C4,Sum} = A + B + C0, one cycle latency.
// The adder accepts a new operand set on every rising clock edge.
// Optional feature macro: ADDER_OVERFLOW_EN.
//   When this macro is defined, the adder adds a registered two's-complement
//   overflow output V. V is the XOR of the carry into the top bit and the
//   carry out of the top bit.
//   When the macro is undefined, the V port and its register do not exist.
// All output registers clear immediately on the falling edge of rst_n.
// A reset therefore discards any in-flight result, so the outputs never
// show a partial value.
module adder_4bit_df
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C0,
   output logic [WIDTH-1:0] Sum,
`ifdef ADDER_OVERFLOW_EN
   output logic             C4,
   output logic             V
`else
   output logic             C4
`endif
);

   // Combinational results from the lookahead core.
   logic [WIDTH-1:0] sum_comb;
   logic             cout_comb;
`ifdef ADDER_OVERFLOW_EN
   logic             cmsb;
`else
   logic             unused_cmsb;
`endif

   cla_4bit_df #(
      .WIDTH (WIDTH)
   ) u_cla (
      .a    (A),
      .b    (B),
      .cin  (C0),
      .sum  (sum_comb),
      .cout (cout_comb),
`ifdef ADDER_OVERFLOW_EN
      .cmsb (cmsb)
`else
      .cmsb (unused_cmsb)
`endif
   );

   // Capture the sum and carry-out every cycle. Reset clears them at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Sum <= '0;
         C4  <= 1'b0;
      end else begin
         Sum <= sum_comb;
         C4  <= cout_comb;
      end
   end

`ifdef ADDER_OVERFLOW_EN
   // Signed overflow occurs when the carry into the top bit differs from
   // the carry out of it. V is registered alongside Sum so the two stay aligned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         V <= 1'b0;
      end else begin
         V <= cout_comb ^ cmsb;
      end
   end
`endif

endmodule : adder_4bit_df

// File: tb/tb_adder_4bit_df.sv
// Self-checking testbench for adder_4bit_df.
// The bench covers the following cases:
//   - a table of directed vectors, including the overflow cases;
//   - the asynchronous reset sequence;
//   - back-to-back random vectors.
// Each case is compared against a plain-arithmetic reference model.
// Define ADDER_OVERFLOW_EN to also check the V output.
module tb_adder_4bit_df;
   import adder_pkg::*;

   logic        clk;
   logic        rst_n;
   adder_word_t A;
   adder_word_t B;
   logic        C0;
   adder_word_t Sum;
   logic        C4;
`ifdef ADDER_OVERFLOW_EN
   logic        V;
`endif

   int checks;
   int errors;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       c0;
      logic [3:0] expSum;
      logic       expC4;
      logic       expV;
   } vec_t;

   vec_t vecs [9];

   adder_4bit_df dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (A),
      .B     (B),
      .C0    (C0),
      .Sum   (Sum),
`ifdef ADDER_OVERFLOW_EN
      .C4    (C4),
      .V     (V)
`else
      .C4    (C4)
`endif
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model for the unsigned result: the 5-bit value of a + b + c0.
   function automatic logic [4:0] refAdd(input logic [3:0] a, input logic [3:0] b, input logic c0);
      int s;
      s = int'(a) + int'(b) + int'(c0);
      return s[4:0];
   endfunction

   // Reference model for signed overflow: the true signed sum falls outside -8..7.
   function automatic logic refOvf(input logic [3:0] a, input logic [3:0] b, input logic c0);
      int sa;
      int sb;
      int s;
      sa = (int'(a) >= 8) ? int'(a) - 16 : int'(a);
      sb = (int'(b) >= 8) ? int'(b) - 16 : int'(b);
      s  = sa + sb + int'(c0);
      return (s > 7) || (s < -8);
   endfunction

   // Drive one operand set on the falling edge, away from the sampling edge.
   task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic c0);
      @(negedge clk);
      A  = a;
      B  = b;
      C0 = c0;
   endtask

   // Compare the registered outputs with the expected values.
   task automatic checkOutput(input string name, input logic [3:0] expSum, input logic expC4, input logic expV);
      checks++;
      if (Sum !== expSum || C4 !== expC4) begin
         errors++;
         $display("[TB] FAIL %s: got Sum=%h C4=%b, expected Sum=%h C4=%b", name, Sum, C4, expSum, expC4);
      end
`ifdef ADDER_OVERFLOW_EN
      checks++;
      if (V !== expV) begin
         errors++;
         $display("[TB] FAIL %s: got V=%b, expected V=%b", name, V, expV);
      end
`else
      if (expV === 1'bz) $display("[TB] note: V check skipped");
`endif
   endtask

   initial begin
      logic [4:0] r;
      logic [3:0] ra;
      logic [3:0] rb;
      logic       rc;

      checks = 0;
      errors = 0;

      // Directed vectors; expected values are hand-derived constants.
      vecs[0] = '{4'hA, 4'h5, 1'b0, 4'hF, 1'b0, 1'b0};
      vecs[1] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
      vecs[2] = '{4'h5, 4'hA, 1'b0, 4'hF, 1'b0, 1'b0};
      vecs[3] = '{4'h5, 4'hA, 1'b1, 4'h0, 1'b1, 1'b0};
      vecs[4] = '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1, 1'b0};
      vecs[5] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
      vecs[6] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};
      vecs[7] = '{4'h3, 4'h2, 1'b0, 4'h5, 1'b0, 1'b0};
      vecs[8] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};

      // Hold reset from time zero and check the reset state.
      rst_n = 1'b0;
      A     = 4'h9;
      B     = 4'h6;
      C0    = 1'b1;
      #1;
      checkOutput("reset_state", 4'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("reset_held_over_edge", 4'h0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table: each result appears one edge after its inputs.
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c0);
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d", i), vecs[i].expSum, vecs[i].expC4, vecs[i].expV);
      end

      // Assert reset mid-cycle while the result F,1 is still showing.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_immediate", 4'h0, 1'b0, 1'b0);
      A  = 4'h6;
      B  = 4'h8;
      C0 = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("reset_discards_inflight", 4'h0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      r = refAdd(4'h6, 4'h8, 1'b1);
      checkOutput("first_edge_after_reset", r[3:0], r[4], refOvf(4'h6, 4'h8, 1'b1));

      // Back-to-back random vectors: operands change on every cycle.
      for (int i = 0; i < 16; i++) begin
         ra = 4'($urandom_range(15, 0));
         rb = 4'($urandom_range(15, 0));
         rc = 1'($urandom_range(1, 0));
         applyStimulus(ra, rb, rc);
         @(posedge clk);
         #1;
         r = refAdd(ra, rb, rc);
         checkOutput($sformatf("rand%0d_%h_%h_%b", i, ra, rb, rc), r[3:0], r[4], refOvf(ra, rb, rc));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_adder_4bit_df
